// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with start/busy/done handshake.
// Quotient on LO, remainder on HI; signed/unsigned modes and divide-by-zero flag.
module seq_divider #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] HI,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_bmag;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_zero;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;

    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;
    logic [WIDTH:0]   w_pshift;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;
    logic             w_last;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_a_neg  = is_signed & A[WIDTH-1];
    assign w_b_neg  = is_signed & B[WIDTH-1];
    assign w_b_zero = (B == '0);
    assign w_amag   = w_a_neg ? -A : A;
    assign w_bmag   = w_b_neg ? -B : B;

    // One restoring step: shift {P,Q} left, trial-subtract the divisor.
    assign w_pshift = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_diff   = {1'b0, w_pshift} - {2'b00, r_bmag};
    assign w_fits   = ~w_diff[WIDTH+1];
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    assign w_quo = r_sign_q ? -r_q : r_q;
    assign w_rem = r_sign_r ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_bmag   <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_zero   <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Zero divisor keeps raw A in Q so HI can return it untouched.
                        r_q      <= w_b_zero ? A : w_amag;
                        r_bmag   <= w_bmag;
                        r_sign_q <= w_a_neg ^ w_b_neg;
                        r_sign_r <= w_a_neg;
                        r_zero   <= w_b_zero;
                        r_p      <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= w_b_zero ? FIX : CALC;
                    end
                end
                CALC: begin
                    r_p   <= w_fits ? w_diff[WIDTH:0] : w_pshift;
                    r_q   <= {r_q[WIDTH-2:0], w_fits};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_zero) begin
                        r_lo <= '1;
                        r_hi <= r_q;
                    end else begin
                        r_lo <= w_quo;
                        r_hi <= w_rem;
                    end
                    r_dz    <= r_zero;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign LO       = r_lo;
    assign HI       = r_hi;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed scoreboard bench for seq_divider (WIDTH 32 and WIDTH 8 instances).
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        busy;
    logic        done;
    logic        dz;

    logic        start8;
    logic        sgn8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [7:0]  lo8;
    logic [7:0]  hi8;
    logic        busy8;
    logic        done8;
    logic        dz8;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(rst), .start(start), .is_signed(sgn),
        .A(a), .B(b), .LO(lo), .HI(hi),
        .busy(busy), .done(done), .div_zero(dz)
    );

    seq_divider #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(rst), .start(start8), .is_signed(sgn8),
        .A(a8), .B(b8), .LO(lo8), .HI(hi8),
        .busy(busy8), .done(done8), .div_zero(dz8)
    );

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] l,
                           input logic [31:0] h, input logic z);
        exp_t e;
        chk({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_lo"}, 64'(l), 64'(e.lo));
            chk({tag, "_hi"}, 64'(h), 64'(e.hi));
            chk({tag, "_dz"}, 64'(z), 64'(e.dz));
        end
    endtask

    task automatic run_op(input string tag, input logic s,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] elo, input logic [31:0] ehi,
                          input logic edz, input int elat, input int poke);
        int n;
        int bc;
        sb.push_back({elo, ehi, edz});
        @(negedge clk);
        sgn = s; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~av; b = bv ^ 32'h5A; sgn = ~s;
        n  = 1;
        bc = int'(busy);
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
            bc += int'(busy);
            start = (n == poke);
            if (n == poke) begin
                a = 32'd1000;
                b = 32'd3;
            end
        end
        start = 1'b0;
        chk({tag, "_lat"}, 64'(n), 64'(elat));
        chk({tag, "_busycyc"}, 64'(bc), 64'(elat - 1));
        chk({tag, "_busy_off"}, 64'(busy), 64'd0);
        pop_chk(tag, lo, hi, dz);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        int first;
        int second;
        int seen;
        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(dz), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 0);
        run_op("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34, 0);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
               32'hFFFFFFFD, 32'd1, 1'b0, 34, 0);
        run_op("u_f9_2", 1'b0, 32'hFFFFFFF9, 32'd2,
               32'h7FFFFFFC, 32'd1, 1'b0, 34, 0);
        run_op("dz_s", 1'b1, 32'h12345678, 32'd0,
               32'hFFFFFFFF, 32'h12345678, 1'b1, 2, 0);
        run_op("dz_u", 1'b0, 32'h12345678, 32'd0,
               32'hFFFFFFFF, 32'h12345678, 1'b1, 2, 0);
        run_op("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 0);
        run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
               32'h80000000, 32'd0, 1'b0, 34, 0);
        run_op("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1,
               32'hFFFFFFFF, 32'd0, 1'b0, 34, 0);
        run_op("u5_9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 34, 0);
        run_op("ignore", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 10);

        // start held high: two back-to-back operations
        sb.push_back({32'd6, 32'd2, 1'b0});
        sb.push_back({32'd6, 32'd2, 1'b0});
        @(negedge clk);
        sgn = 1'b0; a = 32'd20; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        n = 1; first = 0; second = 0;
        while (second == 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                pop_chk("b2b", lo, hi, dz);
                if (first == 0) first = n;
                else second = n;
            end
            if (first != 0 && n == first + 1) begin
                chk("b2b_reaccept", 64'(busy), 64'd1);
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_first", 64'(first), 64'd34);
        chk("b2b_gap", 64'(second - first), 64'd34);

        // reset in the middle of an operation
        @(negedge clk);
        a = 32'd50; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (n < 15) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_lo_held", 64'(lo), 64'd6);
        rst = 1'b1;
        #1;
        chk("arst_lo", 64'(lo), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            seen += int'(done);
        end
        chk("arst_no_done", 64'(seen), 64'd0);

        // WIDTH = 8 signed -128 / 3
        sb.push_back({32'h000000D6, 32'h000000FE, 1'b0});
        @(negedge clk);
        sgn8 = 1'b1; a8 = 8'h80; b8 = 8'd3; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h11; b8 = 8'h00; sgn8 = 1'b0;
        n = 1;
        while (!done8 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w8_lat", 64'(n), 64'd10);
        pop_chk("w8", {24'b0, lo8}, {24'b0, hi8}, dz8);
        chk("w8_busy_off", 64'(busy8), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
